membus_mem: RTL and testbench
=============================

MEMBUS_MEM -- requirements
Module: membus_mem

Interface
REQ-001 Parameter NPORTS, default 4, number of membus ports (1..4).
REQ-002 Parameter AW, default 14, word-address width; depth 2^AW words (AW 4..15).
REQ-003 Parameter FAST, default 0, 1 = answers only when fmc_select=1 (fast memory), 0 = only when fmc_select=0.
REQ-004 Parameter RDLAT, default 3, clocks from addr_ack to rd_rs (1..15).
REQ-005 Parameter RR, default 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 highest).
REQ-006 clk  in  1  system clock; all state changes on rising edge.
REQ-007 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-008 power  in  1  1 = memory powered; 0 = ignore all requests.
REQ-009 sw_sel  in  4  module select switches, compared to membus_sel.
REQ-010 membus_rq_cyc/rd_rq/wr_rq/fmc_select/wr_rs  in  NPORTS each  per-port request, read, write, fast-select, write-restart strobe.
REQ-011 membus_ma  in  15*NPORTS  per-port word address (bits 21:35).
REQ-012 membus_sel  in  4*NPORTS  per-port module select (bits 18:21).
REQ-013 membus_mb_in  in  36*NPORTS  per-port write data.
REQ-014 membus_mb_out  out  36*NPORTS  per-port read data; all-zero when not driving (wired-OR bus).
REQ-015 membus_addr_ack/rd_rs  out  NPORTS each  per-port one-clock pulses.

Function
REQ-016 Port p eligible when power=1, rq_cyc[p]=1, sel[p]=sw_sel, fmc_select[p]=FAST, and (rd_rq[p] or wr_rq[p]).
REQ-017 States: IDLE, ACK, RDWAIT, RS, HOLD, WRWAIT; one cycle in service at a time.
REQ-018 IDLE: if any port eligible, grant one and go ACK; grant registered, stable until back in IDLE.
REQ-019 RR=1: search starts at port after last granted, wrapping NPORTS-1 -> 0; after reset last granted = NPORTS-1 (port 0 first). RR=0: lowest eligible index wins.
REQ-020 ACK: addr_ack[g]=1 for exactly one clock; latch ma[g] low AW bits (upper bits ignored, aliasing), rd_rq, wr_rq.
REQ-021 Read (rd_rq=1): RDWAIT counts RDLAT-1 clocks, then RS: rd_rs[g]=1 one clock, mb_out[g]=mem[addr] same clock.
REQ-022 Read-only: after RS go HOLD; mb_out[g] keeps data until rq_cyc[g]=0, then IDLE.
REQ-023 Read-modify-write (rd_rq and wr_rq): after RS go WRWAIT; mb_out[g] zero from next clock.
REQ-024 Write-only: ACK -> WRWAIT directly, no rd_rs.
REQ-025 WRWAIT: on wr_rs[g]=1 write mb_in[g] to mem[addr], go IDLE same edge; mb_out stays zero.
REQ-026 Abort: rq_cyc[g]=0 in any non-IDLE state after ACK -> IDLE next clock, no write, outputs zero; addr_ack pulse already issued is not retracted.
REQ-027 power=0 in any state -> IDLE next clock, no write; memory contents retained.
REQ-028 New grant possible the clock after return to IDLE (minimum 1 idle clock between cycles).
REQ-029 Requests from non-granted ports are held pending, never acked, until granted.
REQ-030 Non-granted ports: addr_ack, rd_rs, mb_out always 0.

Reset
REQ-031 reset low: state IDLE, counters 0, grant pointer NPORTS-1, all outputs 0 asynchronously.
REQ-032 Memory array not cleared by reset; reset mid-cycle discards pending write.

Structure
REQ-033 Shared package: state encoding, membus field widths (MA 15, SEL 4, MB 36), port-count limit.
REQ-034 One sub-module membus_arb: NPORTS eligible vector + last grant -> grant index, fixed/RR mode.
REQ-035 Memory array plain register array, simulation-accessible by hierarchical name for preload.

Verification
REQ-036 Preload mem[o105]=o1234, port0 read-only ma=o105 -> addr_ack 1 clk, rd_rs RDLAT clks later, mb_out0=o000000001234 until rq_cyc drops.
REQ-037 Port1 write-only ma=o200, wr_rs with mb_in=o777777000000 -> mem[o200] equals it; mb_out1 zero throughout.
REQ-038 RMW port0 ma=o10 (o5), write back o6 on wr_rs -> rd_rs data o5, then mem[o10]=o6.
REQ-039 Ports 0,2,3 request simultaneously, RR=1 -> grants 0,2,3, then 0 again on re-request; RR=0 -> 0 repeatedly while 0 re-requests.
REQ-040 sel mismatch or wrong fmc_select -> no addr_ack ever; rq_cyc dropped in WRWAIT -> memory unchanged, IDLE next clock.
REQ-041 reset asserted during RDWAIT -> all outputs 0 immediately; post-reset read returns preloaded value unchanged.

Source files
------------

// File: rtl/membus_mem_pkg.sv
// Shared membus definitions: bus field widths, port-count limit, core FSM state encoding.
// Pure definitions; no timing or flow-control implications.
package membus_mem_pkg;

    localparam int MA_W      = 15;
    localparam int SEL_W     = 4;
    localparam int MB_W      = 36;
    localparam int MAX_PORTS = 4;
    localparam int GNT_W     = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACK    = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_RS     = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_WRWAIT = 3'd5;

    function automatic logic [MAX_PORTS-1:0] port_onehot(input logic [GNT_W-1:0] idx);
        return MAX_PORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/membus_arb.sv
// Combinational port arbiter: picks one eligible port, round-robin from last grant or fixed (port 0 first).
// Zero latency; losing ports simply stay pending, nothing is dropped.
module membus_arb
    import membus_mem_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int RR     = 1
) (
    input  logic [NPORTS-1:0] elig,
    input  logic [GNT_W-1:0]  last,
    output logic [GNT_W-1:0]  grant,
    output logic              any
);

    logic [MAX_PORTS-1:0] elig_pad;

    assign elig_pad = MAX_PORTS'(elig);

    always_comb begin
        int idx;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            // Round-robin starts just past the previous winner and wraps.
            idx = (RR != 0) ? (int'(last) + 1 + i) % NPORTS : i;
            if (!any && elig_pad[idx[GNT_W-1:0]]) begin
                any   = 1'b1;
                grant = idx[GNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/membus_mem.sv
// Multi-port membus core memory: one cycle in service, read at RDLAT clocks after addr_ack, RMW and write-only.
// Non-granted requests are held pending by the master until arbitration selects them.
module membus_mem
    import membus_mem_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int AW     = 14,
    parameter int FAST   = 0,
    parameter int RDLAT  = 3,
    parameter int RR     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    power,
    input  logic [SEL_W-1:0]        sw_sel,
    input  logic [NPORTS-1:0]       membus_rq_cyc,
    input  logic [NPORTS-1:0]       membus_rd_rq,
    input  logic [NPORTS-1:0]       membus_wr_rq,
    input  logic [NPORTS-1:0]       membus_fmc_select,
    input  logic [NPORTS-1:0]       membus_wr_rs,
    input  logic [MA_W*NPORTS-1:0]  membus_ma,
    input  logic [SEL_W*NPORTS-1:0] membus_sel,
    input  logic [MB_W*NPORTS-1:0]  membus_mb_in,
    output logic [MB_W*NPORTS-1:0]  membus_mb_out,
    output logic [NPORTS-1:0]       membus_addr_ack,
    output logic [NPORTS-1:0]       membus_rd_rs
);

    logic [2:0]           state;
    logic [GNT_W-1:0]     gnt;
    logic [GNT_W-1:0]     last_gnt;
    logic [GNT_W-1:0]     arb_gnt;
    logic                 arb_any;
    logic [3:0]           cnt;
    logic [AW-1:0]        addr;
    logic                 wr_f;
    logic [MB_W-1:0]      rdata;
    logic                 we;
    logic                 unused_ma;

    logic [NPORTS-1:0]    elig;
    logic [MAX_PORTS-1:0] rq_cyc_p;
    logic [MAX_PORTS-1:0] rd_p;
    logic [MAX_PORTS-1:0] wr_p;
    logic [MAX_PORTS-1:0] wr_rs_p;
    logic [AW-1:0]        ma_lo [MAX_PORTS];
    logic [MB_W-1:0]      mb_in_p [MAX_PORTS];

    logic [MB_W-1:0]      mem [0:(1<<AW)-1];

    // Upper address bits are deliberately ignored: addresses alias modulo the depth.
    assign unused_ma = ^membus_ma;

    always_comb begin
        elig     = '0;
        rq_cyc_p = '0;
        rd_p     = '0;
        wr_p     = '0;
        wr_rs_p  = '0;
        for (int p = 0; p < MAX_PORTS; p++) begin
            ma_lo[p]   = '0;
            mb_in_p[p] = '0;
        end
        for (int p = 0; p < NPORTS; p++) begin
            rq_cyc_p[p] = membus_rq_cyc[p];
            rd_p[p]     = membus_rd_rq[p];
            wr_p[p]     = membus_wr_rq[p];
            wr_rs_p[p]  = membus_wr_rs[p];
            ma_lo[p]    = membus_ma[p*MA_W +: AW];
            mb_in_p[p]  = membus_mb_in[p*MB_W +: MB_W];
            elig[p]     = power && membus_rq_cyc[p]
                          && (membus_sel[p*SEL_W +: SEL_W] == sw_sel)
                          && (membus_fmc_select[p] == (FAST != 0))
                          && (membus_rd_rq[p] || membus_wr_rq[p]);
        end
    end

    membus_arb #(
        .NPORTS (NPORTS),
        .RR     (RR)
    ) u_arb (
        .elig   (elig),
        .last   (last_gnt),
        .grant  (arb_gnt),
        .any    (arb_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            last_gnt <= GNT_W'(NPORTS - 1);
            cnt      <= '0;
            addr     <= '0;
            wr_f     <= 1'b0;
            rdata    <= '0;
        end else if (!power) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        gnt      <= arb_gnt;
                        last_gnt <= arb_gnt;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    addr <= ma_lo[gnt];
                    wr_f <= wr_p[gnt];
                    cnt  <= 4'(RDLAT - 1);
                    if (!rq_cyc_p[gnt]) begin
                        state <= S_IDLE;
                    end else if (rd_p[gnt]) begin
                        state <= (RDLAT == 1) ? S_RS : S_RDWAIT;
                    end else if (wr_p[gnt]) begin
                        state <= S_WRWAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RDWAIT: begin
                    if (!rq_cyc_p[gnt]) begin
                        state <= S_IDLE;
                    end else if (cnt <= 4'd1) begin
                        state <= S_RS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RS: begin
                    rdata <= mem[addr];
                    if (!rq_cyc_p[gnt]) begin
                        state <= S_IDLE;
                    end else if (wr_f) begin
                        state <= S_WRWAIT;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!rq_cyc_p[gnt]) begin
                        state <= S_IDLE;
                    end
                end
                S_WRWAIT: begin
                    if (!rq_cyc_p[gnt] || wr_rs_p[gnt]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // An abort (rq_cyc low) takes precedence over a simultaneous wr_rs.
    assign we = reset && power && (state == S_WRWAIT) && rq_cyc_p[gnt] && wr_rs_p[gnt];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= mb_in_p[gnt];
        end
    end

    always_comb begin
        membus_addr_ack = '0;
        membus_rd_rs    = '0;
        membus_mb_out   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt == GNT_W'(p)) begin
                membus_addr_ack[p] = (state == S_ACK);
                membus_rd_rs[p]    = (state == S_RS);
                if (state == S_RS) begin
                    membus_mb_out[p*MB_W +: MB_W] = mem[addr];
                end else if (state == S_HOLD) begin
                    membus_mb_out[p*MB_W +: MB_W] = rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_membus_mem.sv
// Directed bench for membus_mem: reads, writes, RMW, arbitration (RR and fixed), filtering, abort, reset.
module tb_membus_mem;
    import membus_mem_pkg::*;

    localparam int NP    = 4;
    localparam int RDLAT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              power = 1'b0;
    logic              power_fp = 1'b0;
    logic [3:0]        sw_sel;
    logic [NP-1:0]     rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
    logic [15*NP-1:0]  ma;
    logic [4*NP-1:0]   sel;
    logic [36*NP-1:0]  mb_in;
    logic [36*NP-1:0]  mb_out, mb_out_fp;
    logic [NP-1:0]     ack, ack_fp, rs, rs_fp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    membus_mem #(.NPORTS(NP), .AW(14), .FAST(0), .RDLAT(RDLAT), .RR(1)) dut (
        .clk(clk), .reset(reset), .power(power), .sw_sel(sw_sel),
        .membus_rq_cyc(rq_cyc), .membus_rd_rq(rd_rq), .membus_wr_rq(wr_rq),
        .membus_fmc_select(fmc), .membus_wr_rs(wr_rs), .membus_ma(ma),
        .membus_sel(sel), .membus_mb_in(mb_in), .membus_mb_out(mb_out),
        .membus_addr_ack(ack), .membus_rd_rs(rs)
    );

    membus_mem #(.NPORTS(NP), .AW(14), .FAST(0), .RDLAT(RDLAT), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .power(power_fp), .sw_sel(sw_sel),
        .membus_rq_cyc(rq_cyc), .membus_rd_rq(rd_rq), .membus_wr_rq(wr_rq),
        .membus_fmc_select(fmc), .membus_wr_rs(wr_rs), .membus_ma(ma),
        .membus_sel(sel), .membus_mb_in(mb_in), .membus_mb_out(mb_out_fp),
        .membus_addr_ack(ack_fp), .membus_rd_rs(rs_fp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read-only cycle on port p, checking ack latency, RDLAT, data and hold.
    task automatic do_read(input int p, input logic [14:0] a, input logic [35:0] exp, input string tag);
        int n;
        ma[p*15 +: 15] = a;
        rd_rq[p]  = 1'b1;
        rq_cyc[p] = 1'b1;
        n = 0;
        while (ack[p] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ack_dly"}, 64'(n), 64'd1);
        tick();
        check({tag, "_ack_pulse"}, 64'(ack), 64'd0);
        n = 1;
        while (rs[p] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdlat"}, 64'(n), 64'(RDLAT));
        check({tag, "_rs_data"}, 64'(mb_out[p*36 +: 36]), 64'(exp));
        tick();
        check({tag, "_rs_pulse"}, 64'(rs), 64'd0);
        check({tag, "_hold_data"}, 64'(mb_out[p*36 +: 36]), 64'(exp));
        rq_cyc[p] = 1'b0;
        rd_rq[p]  = 1'b0;
        tick();
        check({tag, "_release"}, 64'(|mb_out), 64'd0);
    endtask

    // Waits for the next grant on one DUT, checks which port, then completes it as a write.
    task automatic serve(input bit fp, input int exp_port, input string tag);
        int n;
        logic [NP-1:0] a;
        n = 0;
        a = fp ? ack_fp : ack;
        while (a == '0 && n < 10) begin
            tick();
            n++;
            a = fp ? ack_fp : ack;
        end
        check(tag, 64'(a), 64'(1 << exp_port));
        wr_rs = a;
        tick();
        tick();
        wr_rs = '0;
    endtask

    initial begin
        logic [NP-1:0] acc;
        sw_sel = 4'd5;
        sel    = {NP{4'd5}};
        fmc    = '0;
        rq_cyc = '0;
        rd_rq  = '0;
        wr_rq  = '0;
        wr_rs  = '0;
        ma     = '0;
        mb_in  = '0;

        dut.mem[14'o105] = 36'o1234;
        dut.mem[14'o10]  = 36'o5;
        dut.mem[14'o300] = 36'o17;
        dut.mem[14'o200] = 36'o0;

        tick();
        tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_rs", 64'(rs), 64'd0);
        check("rst_mb_out", 64'(|mb_out), 64'd0);
        check("rst_state", 64'(dut.state), 64'(S_IDLE));
        power = 1'b1;
        reset = 1'b1;
        tick();

        // Read-only on port 0.
        do_read(0, 15'o105, 36'o000000001234, "rd0");

        // Write-only on port 1.
        ma[15 +: 15]  = 15'o200;
        mb_in[36 +: 36] = 36'o777777000000;
        wr_rq[1]  = 1'b1;
        rq_cyc[1] = 1'b1;
        tick();
        check("wr1_ack", 64'(ack), 64'b0010);
        check("wr1_mb_ack", 64'(|mb_out), 64'd0);
        tick();
        check("wr1_mb_wait", 64'(|mb_out), 64'd0);
        check("wr1_no_rs", 64'(rs), 64'd0);
        wr_rs[1] = 1'b1;
        tick();
        wr_rs    = '0;
        rq_cyc   = '0;
        wr_rq    = '0;
        check("wr1_mb_done", 64'(|mb_out), 64'd0);
        check("wr1_mem", 64'(dut.mem[14'o200]), 64'(36'o777777000000));

        // Read-modify-write on port 0.
        tick();
        ma[0 +: 15] = 15'o10;
        rd_rq[0]  = 1'b1;
        wr_rq[0]  = 1'b1;
        rq_cyc[0] = 1'b1;
        tick();
        check("rmw_ack", 64'(ack), 64'b0001);
        tick();
        tick();
        tick();
        check("rmw_rs", 64'(rs), 64'b0001);
        check("rmw_rd_data", 64'(mb_out[0 +: 36]), 64'o5);
        tick();
        check("rmw_mb_zero", 64'(|mb_out), 64'd0);
        check("rmw_state", 64'(dut.state), 64'(S_WRWAIT));
        mb_in[0 +: 36] = 36'o6;
        wr_rs[0] = 1'b1;
        tick();
        wr_rs  = '0;
        rq_cyc = '0;
        rd_rq  = '0;
        wr_rq  = '0;
        check("rmw_mem", 64'(dut.mem[14'o10]), 64'o6);
        tick();

        // Module-select mismatch on port 1, wrong fast-select on port 2.
        sel[4 +: 4] = 4'd6;
        fmc[2]    = 1'b1;
        rd_rq     = 4'b0110;
        rq_cyc    = 4'b0110;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc = acc | ack;
        end
        check("filter_no_ack", 64'(acc), 64'd0);
        rq_cyc = '0;
        rd_rq  = '0;
        sel[4 +: 4] = 4'd5;
        fmc[2] = 1'b0;
        tick();

        // Abort in WRWAIT on port 3: a coincident wr_rs must not write.
        ma[45 +: 15] = 15'o300;
        mb_in[108 +: 36] = 36'o55;
        wr_rq[3]  = 1'b1;
        rq_cyc[3] = 1'b1;
        tick();
        check("abort_ack", 64'(ack), 64'b1000);
        tick();
        rq_cyc[3] = 1'b0;
        wr_rs[3]  = 1'b1;
        tick();
        check("abort_idle", 64'(dut.state), 64'(S_IDLE));
        wr_rs = '0;
        wr_rq = '0;
        tick();
        check("abort_mem", 64'(dut.mem[14'o300]), 64'o17);

        // Round-robin: ports 0,2,3 all keep requesting.
        for (int p = 0; p < NP; p++) begin
            ma[p*15 +: 15]  = 15'(15'o500 + p);
            mb_in[p*36 +: 36] = 36'(p + 1);
        end
        wr_rq  = 4'b1101;
        rq_cyc = 4'b1101;
        serve(1'b0, 0, "rr_g1");
        serve(1'b0, 2, "rr_g2");
        serve(1'b0, 3, "rr_g3");
        serve(1'b0, 0, "rr_g4");
        rq_cyc = '0;
        wr_rq  = '0;
        tick();
        tick();

        // Fixed priority on the second instance; first instance powered down.
        power    = 1'b0;
        power_fp = 1'b1;
        wr_rq  = 4'b1101;
        rq_cyc = 4'b1101;
        serve(1'b1, 0, "fp_g1");
        serve(1'b1, 0, "fp_g2");
        serve(1'b1, 0, "fp_g3");
        check("pwr_off_ack", 64'(ack), 64'd0);
        check("pwr_off_state", 64'(dut.state), 64'(S_IDLE));
        rq_cyc = '0;
        wr_rq  = '0;
        tick();
        power_fp = 1'b0;
        power    = 1'b1;
        tick();

        // Reset during RDWAIT.
        ma[0 +: 15] = 15'o105;
        rd_rq[0]  = 1'b1;
        rq_cyc[0] = 1'b1;
        tick();
        tick();
        check("rstrd_state", 64'(dut.state), 64'(S_RDWAIT));
        reset = 1'b0;
        #1;
        check("rstrd_state_now", 64'(dut.state), 64'(S_IDLE));
        check("rstrd_outs", 64'({ack, rs, |mb_out}), 64'd0);
        rq_cyc = '0;
        rd_rq  = '0;
        tick();
        reset = 1'b1;
        tick();

        // Reset during HOLD must clear the driven data immediately.
        rd_rq[0]  = 1'b1;
        rq_cyc[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rsthold_data", 64'(mb_out[0 +: 36]), 64'o1234);
        reset = 1'b0;
        #1;
        check("rsthold_mb_zero", 64'(|mb_out), 64'd0);
        rq_cyc = '0;
        rd_rq  = '0;
        tick();
        reset = 1'b1;
        tick();

        do_read(0, 15'o105, 36'o1234, "post_rst");
        do_read(1, 15'o200, 36'o777777000000, "post_rst_wr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
